fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_pkg.sv | 18 +
 rtl/fetch_stage_if.sv | 24 ++
 rtl/fetch_stage_pc_reg.sv | 26 ++
 rtl/fetch_stage.sv | 108 ++++++++++
 tb/tb_fetch_stage.sv | 155 +++++++++++++++
 5 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared pipeline constants for the front end: fetch FSM encodings and the IF/ID bubble value.
package fetch_stage_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_VALID = 2'd2,
    S_DROP  = 2'd3
  } fetch_state_t;

  localparam logic [31:0] BUBBLE = 32'h0000_0000;

  // Redirect targets are forced onto a word boundary.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage signal bundle: redirect/hazard inputs, instruction-memory handshake, IF/ID outputs.
interface fetch_stage_if;
  logic        hazDetect_IF_ID;
  logic        PCSrc;
  logic [31:0] branchTarget_i;
  logic        imemReq_o;
  logic [31:0] imemAddr_o;
  logic        imemReady_i;
  logic [31:0] imemData_i;
  logic [31:0] pc_o;
  logic [31:0] pcPlusFour_o;
  logic [31:0] inst_o;
  logic        instValid_o;

  modport master (
    input  hazDetect_IF_ID, PCSrc, branchTarget_i, imemReady_i, imemData_i,
    output imemReq_o, imemAddr_o, pc_o, pcPlusFour_o, inst_o, instValid_o
  );

  modport slave (
    output hazDetect_IF_ID, PCSrc, branchTarget_i, imemReady_i, imemData_i,
    input  imemReq_o, imemAddr_o, pc_o, pcPlusFour_o, inst_o, instValid_o
  );
endinterface

// File: rtl/fetch_stage_pc_reg.sv
// Program counter: resets to RESET_PC, redirect has priority over sequential +4 (wraps mod 2^32).
module pc_reg #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        advance,
  input  logic        redirect,
  input  logic [31:0] redirect_addr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus_four
);

  assign pc_plus_four = pc + 32'd4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (redirect) begin
      pc <= redirect_addr;
    end else if (advance) begin
      pc <= pc_plus_four;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: one outstanding imem request, buffers the word until IF/ID takes it.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic           clk,
  input  logic           rst_n,
  fetch_stage_if.master  fif
);

  fetch_state_t state, state_nxt;
  logic [31:0]  inst_buf;
  logic [31:0]  pend_target;
  logic [31:0]  pc;
  logic [31:0]  pc_plus_four;
  logic [31:0]  target;

  logic         buf_load;
  logic         pend_load;
  logic         pc_advance;
  logic         pc_redirect;
  logic [31:0]  redirect_addr;
  logic         inst_valid;

  assign target = word_align(fif.branchTarget_i);

  pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
    .clk           (clk),
    .rst_n         (rst_n),
    .advance       (pc_advance),
    .redirect      (pc_redirect),
    .redirect_addr (redirect_addr),
    .pc            (pc),
    .pc_plus_four  (pc_plus_four)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      inst_buf    <= 32'h0;
      pend_target <= 32'h0;
    end else begin
      state <= state_nxt;
      if (buf_load)  inst_buf    <= fif.imemData_i;
      if (pend_load) pend_target <= target;
    end
  end

  always_comb begin
    state_nxt     = state;
    fif.imemReq_o = 1'b0;
    inst_valid    = 1'b0;
    buf_load      = 1'b0;
    pend_load     = 1'b0;
    pc_advance    = 1'b0;
    pc_redirect   = 1'b0;
    redirect_addr = target;

    unique case (state)
      S_IDLE: begin
        state_nxt = S_FETCH;
      end
      S_FETCH: begin
        fif.imemReq_o = 1'b1;
        if (fif.imemReady_i) begin
          if (fif.PCSrc) begin
            pc_redirect = 1'b1;
          end else begin
            buf_load  = 1'b1;
            state_nxt = S_VALID;
          end
        end else if (fif.PCSrc) begin
          pend_load = 1'b1;
          state_nxt = S_DROP;
        end
      end
      S_DROP: begin
        // The old request must still complete; its data is thrown away.
        fif.imemReq_o = 1'b1;
        if (fif.PCSrc) pend_load = 1'b1;
        if (fif.imemReady_i) begin
          pc_redirect   = 1'b1;
          redirect_addr = fif.PCSrc ? target : pend_target;
          state_nxt     = S_FETCH;
        end
      end
      S_VALID: begin
        inst_valid = ~fif.PCSrc;
        if (fif.PCSrc) begin
          pc_redirect = 1'b1;
          state_nxt   = S_FETCH;
        end else if (fif.hazDetect_IF_ID) begin
          pc_advance = 1'b1;
          state_nxt  = S_FETCH;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign fif.imemAddr_o   = pc;
  assign fif.pc_o         = pc;
  assign fif.pcPlusFour_o = pc_plus_four;
  assign fif.instValid_o  = inst_valid;
  assign fif.inst_o       = inst_valid ? inst_buf : BUBBLE;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed test of fetch_stage: two instances, RESET_PC = 0 and RESET_PC = 32'hFFFF_FFFC.
module tb_fetch_stage;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  fetch_stage_if fa ();
  fetch_stage_if fb ();

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut_a (.clk(clk), .rst_n(rst_n), .fif(fa));
  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_b (.clk(clk), .rst_n(rst_n), .fif(fb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    fa.hazDetect_IF_ID = 1'b0; fa.PCSrc = 1'b0; fa.branchTarget_i = 32'h0;
    fa.imemReady_i     = 1'b0; fa.imemData_i = 32'h0;
    fb.hazDetect_IF_ID = 1'b0; fb.PCSrc = 1'b0; fb.branchTarget_i = 32'h0;
    fb.imemReady_i     = 1'b0; fb.imemData_i = 32'hDEAD_BEEF;
    step();
    step();

    // Reset state
    check("rst_req",   32'(fa.imemReq_o),   32'h0);
    check("rst_valid", 32'(fa.instValid_o), 32'h0);
    check("rst_inst",  fa.inst_o,           32'h0);
    check("rst_pc",    fa.pc_o,             32'h0);
    check("rst_pc_b",  fb.pc_o,             32'hFFFF_FFFC);
    check("rst_pc4_b", fb.pcPlusFour_o,     32'h0000_0000);

    rst_n = 1'b1;
    fa.imemReady_i = 1'b1; fa.hazDetect_IF_ID = 1'b1; fa.imemData_i = 32'h1111_0001;
    fb.imemReady_i = 1'b1; fb.hazDetect_IF_ID = 1'b1;

    // Streaming with a 1-cycle memory
    step();
    check("f0_req",   32'(fa.imemReq_o),   32'h1);
    check("f0_addr",  fa.imemAddr_o,       32'h0);
    check("f0_valid", 32'(fa.instValid_o), 32'h0);
    check("b_addr0",  fb.imemAddr_o,       32'hFFFF_FFFC);
    step();
    check("v0_valid", 32'(fa.instValid_o), 32'h1);
    check("v0_inst",  fa.inst_o,           32'h1111_0001);
    check("v0_pc4",   fa.pcPlusFour_o,     32'h4);
    check("v0_req",   32'(fa.imemReq_o),   32'h0);
    fa.imemData_i = 32'h2222_0002;
    step();
    check("f1_addr",  fa.imemAddr_o,       32'h4);
    check("f1_inst",  fa.inst_o,           32'h0);
    check("b_addr1",  fb.imemAddr_o,       32'h0000_0000);
    step();
    check("v1_valid", 32'(fa.instValid_o), 32'h1);

    // Stall in VALID
    fa.hazDetect_IF_ID = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_valid", 32'(fa.instValid_o), 32'h1);
      check("stall_inst",  fa.inst_o,           32'h2222_0002);
      check("stall_pc",    fa.pc_o,             32'h4);
      check("stall_req",   32'(fa.imemReq_o),   32'h0);
    end
    fa.hazDetect_IF_ID = 1'b1;
    step();
    check("f2_addr", fa.imemAddr_o, 32'h8);

    // Redirect while memory is slow -> DROP
    fa.imemReady_i = 1'b0; fa.PCSrc = 1'b1; fa.branchTarget_i = 32'h0000_0103;
    fa.imemData_i  = 32'h3333_0008;
    step();
    check("drop_addr", fa.imemAddr_o,     32'h8);
    check("drop_req",  32'(fa.imemReq_o), 32'h1);
    fa.PCSrc = 1'b0; fa.branchTarget_i = 32'h0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("drop_hold_addr",  fa.imemAddr_o,       32'h8);
      check("drop_hold_valid", 32'(fa.instValid_o), 32'h0);
    end
    fa.imemReady_i = 1'b1;
    step();
    check("redir_addr", fa.imemAddr_o, 32'h0000_0100);
    check("redir_inst", fa.inst_o,     32'h0);
    fa.imemData_i = 32'h4444_0100;
    step();
    check("v_redir_inst", fa.inst_o, 32'h4444_0100);
    check("v_redir_pc",   fa.pc_o,   32'h0000_0100);

    // Redirect in VALID beats hazDetect
    fa.PCSrc = 1'b1; fa.branchTarget_i = 32'h0000_0200;
    #1;
    check("vredir_valid", 32'(fa.instValid_o), 32'h0);
    check("vredir_inst",  fa.inst_o,           32'h0);
    step();
    check("vredir_addr", fa.imemAddr_o, 32'h0000_0200);

    // Redirect coincident with acceptance in FETCH
    fa.branchTarget_i = 32'h0000_0302;
    step();
    check("fredir_addr",  fa.imemAddr_o,       32'h0000_0300);
    check("fredir_state", 32'(fa.imemReq_o),   32'h1);
    check("fredir_valid", 32'(fa.instValid_o), 32'h0);
    fa.PCSrc = 1'b0; fa.imemData_i = 32'h5555_0300;
    step();
    check("v3_inst", fa.inst_o, 32'h5555_0300);
    step();
    check("f4_addr", fa.imemAddr_o, 32'h0000_0304);

    // DROP: newest target wins when ready and PCSrc coincide
    fa.imemReady_i = 1'b0; fa.PCSrc = 1'b1; fa.branchTarget_i = 32'h0000_0400;
    step();
    fa.imemReady_i = 1'b1; fa.branchTarget_i = 32'h0000_0500;
    step();
    check("newest_addr", fa.imemAddr_o, 32'h0000_0500);

    // Reset during an outstanding request
    fa.PCSrc = 1'b0; fa.imemReady_i = 1'b0;
    step();
    check("out_req", 32'(fa.imemReq_o), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_req",  32'(fa.imemReq_o), 32'h0);
    check("arst_addr", fa.imemAddr_o,     32'h0);
    step();
    rst_n = 1'b1;
    fa.imemReady_i = 1'b1;
    step();
    check("restart_req",  32'(fa.imemReq_o), 32'h1);
    check("restart_addr", fa.imemAddr_o,     32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
